vid_scanout: RTL and testbench
==============================

Name: vid_scanout

Overview:
- Read-side master for the data memory's second (video) read port.
- Frames are written into data memory by the CPU through the main port. This block walks a framebuffer region word by word via vaddr/vdata.
- Each 32-bit word is split into 8-bit pixels and streamed to a display/serial sink over a valid/ready handshake.
- Sits beside dmem in the top level; the CPU side is untouched.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of first framebuffer byte; must be word aligned.
- NUM_BYTES, 1408, pixels per frame (0x580); need not be a multiple of 4; must be >= 1.
- ADDRESS_WIDTH, 32, width of vaddr.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a frame; ignored while busy=1.
- vaddr  out  32  word-aligned read address to the memory video port, registered.
- vdata  in  32  memory video-port data, valid one edge after vaddr is sampled.
- pix_valid  out  1  pixel available.
- pix_data  out  8  current pixel.
- pix_ready  in  1  sink accepts the pixel when pix_valid & pix_ready at a rising edge.
- pix_last  out  1  high with the final pixel of the frame.
- busy  out  1  high from the edge after start until frame_done.
- frame_done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state=IDLE; vaddr=BASE_ADDR.
  - pix_valid, pix_last, busy and frame_done = 0; pix_data=0.
  - Byte index and byte counter cleared. No partial frame resumes after reset.
- FSM states: IDLE, FETCH, LOAD, SHIFT, DONE.
- IDLE:
  - On start: vaddr<=BASE_ADDR, byte counter<=0, busy<=1, go to FETCH.
- FETCH (1 cycle): vaddr is held stable; the memory registers it at the end of this cycle. Go to LOAD.
- LOAD (1 cycle): vdata is valid. Latch it into the word buffer, set byte index=0, go to SHIFT.
- SHIFT:
  - pix_valid=1; pix_data=buffer byte[index].
  - Byte order is little-endian: byte 0 = bits 7:0, byte 3 = bits 31:24 (same lane order as the memory byte enables).
  - pix_data and pix_last must stay stable while pix_valid & !pix_ready.
  - On accept: counter++.
    - If counter was NUM_BYTES-1, go to DONE.
    - Else if index==3: vaddr<=vaddr+4, go to FETCH.
    - Else index++.
- pix_last = pix_valid & (counter==NUM_BYTES-1).
- Partial last word: unused upper bytes are never emitted.
- DONE (1 cycle): frame_done=1, busy<=0, go to IDLE.
- start asserted in any state other than IDLE is ignored; no queuing.
- start in the same cycle as DONE is also ignored; start is accepted one cycle later.
- vaddr arithmetic is modulo 2^32. vaddr[1:0] is always 0.
- Throughput: 4 pixels per 6 cycles with pix_ready held high (2-cycle FETCH/LOAD bubble per word).

Optional Feature:
- Macro: SCANOUT_PREFETCH_EN.
- Defined:
  - Adds a second word buffer.
  - While SHIFT emits the current word, the next word's vaddr is issued and latched. Only one prefetch is outstanding.
  - On the index==3 accept, SHIFT swaps buffers and continues with no bubble.
  - pix_valid stays high for all NUM_BYTES pixels when pix_ready=1 (1 pixel/cycle after the initial 2-cycle fetch).
  - No prefetch is issued beyond the word containing byte NUM_BYTES-1.
- Undefined: FSM exactly as above, with bubbles.

Decomposition:
- Package scanout_pkg:
  - state enum (IDLE, FETCH, LOAD, SHIFT, DONE).
  - BYTES_PER_WORD=4.
  - Localparam for the word-index width.
- Sub-module pix_serializer: holds the word buffer(s) and byte index, selects pix_data. Instantiated once.
- The FSM, vaddr and counter stay in vid_scanout.

Test Plan:
- Basic frame:
  - Stimulus: NUM_BYTES=8, mem[0]=32'h44332211, mem[1]=32'h88776655, pix_ready=1, start pulse.
  - Required: vaddr 0 then 4; pixels 11,22,…,88 in order; pix_last only on 88; frame_done one cycle after the 88 accept; busy low after that.
- Backpressure:
  - Stimulus: same frame; pix_ready toggled 0/1 each cycle.
  - Required: each pixel held stable while stalled; same 8-pixel sequence, no duplicates or drops.
- Partial word:
  - Stimulus: NUM_BYTES=6.
  - Required: pixels 11..66 only; pix_last on 66; no third fetch (vaddr never 8).
- Start while busy:
  - Stimulus: second start pulse mid-frame.
  - Required: ignored; exactly one frame_done; frame restarts only on a start issued after frame_done.
- Reset mid-frame:
  - Stimulus: rst_n low during SHIFT of word 1.
  - Required: outputs clear immediately; vaddr=BASE_ADDR; next start replays from pixel 11.
- With SCANOUT_PREFETCH_EN:
  - Stimulus: basic frame, pix_ready=1.
  - Required: 8 pixels on 8 consecutive cycles, first pixel 2 cycles after leaving IDLE.

Source files
------------

// File: rtl/vid_scanout_pkg.sv
// scanout_pkg: shared types and constants for the video scanout block.
//   state_e        : scanout FSM states
//   BYTES_PER_WORD : pixels carried by one 32-bit memory word
//   IDX_W          : width of the byte-within-word index
//   byte_lane()    : little-endian byte select (lane 0 = bits 7:0)
// Optional build macro used by the users of this package: SCANOUT_PREFETCH_EN.
package scanout_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    DONE
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);

  function automatic logic [7:0] byte_lane(input logic [31:0] word,
                                           input logic [IDX_W-1:0] idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/vid_scanout_serializer.sv
// pix_serializer: word buffer(s) and byte index for the scanout pixel stream.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   load_i         : latch word_i as the current word, index back to byte 0
//   adv_i          : step to the next byte of the current word
//   word_i         : memory video-port data
//   pf_load_i      : (SCANOUT_PREFETCH_EN) latch word_i into the next-word buffer
//   swap_i         : (SCANOUT_PREFETCH_EN) next-word buffer becomes current, index 0
//   idx_o          : current byte index
//   byte_o         : selected pixel byte
// Build macro: SCANOUT_PREFETCH_EN adds the second (next-word) buffer.
module pix_serializer
  import scanout_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [31:0]      word_i,
`ifdef SCANOUT_PREFETCH_EN
  input  logic             pf_load_i,
  input  logic             swap_i,
`endif
  output logic [IDX_W-1:0] idx_o,
  output logic [7:0]       byte_o
);

  logic [31:0]      cur_q, cur_d;
  logic [IDX_W-1:0] idx_q, idx_d;
`ifdef SCANOUT_PREFETCH_EN
  logic [31:0]      nxt_q, nxt_d;
`endif

  always_comb begin
    cur_d = cur_q;
    idx_d = idx_q;
    if (load_i) begin
      cur_d = word_i;
      idx_d = '0;
    end else if (adv_i) begin
      idx_d = idx_q + 1'b1;
    end
`ifdef SCANOUT_PREFETCH_EN
    nxt_d = nxt_q;
    if (pf_load_i) begin
      nxt_d = word_i;
    end
    if (swap_i) begin
      cur_d = nxt_q;
      idx_d = '0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cur_q <= '0;
      idx_q <= '0;
`ifdef SCANOUT_PREFETCH_EN
      nxt_q <= '0;
`endif
    end else begin
      cur_q <= cur_d;
      idx_q <= idx_d;
`ifdef SCANOUT_PREFETCH_EN
      nxt_q <= nxt_d;
`endif
    end
  end

  assign idx_o  = idx_q;
  assign byte_o = byte_lane(cur_q, idx_q);

endmodule

// File: rtl/vid_scanout.sv
// vid_scanout: read-side master for the data memory's video port. Walks a
// framebuffer word by word and streams its bytes as 8-bit pixels over a
// valid/ready handshake.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   start       : one-cycle frame start pulse, ignored unless idle
//   vaddr       : registered word-aligned read address to the memory video port
//   vdata       : memory video-port data, valid one edge after vaddr is sampled
//   pix_valid/pix_data/pix_ready/pix_last : pixel stream to the sink
//   busy        : frame in progress
//   frame_done  : one-cycle pulse after the last pixel is accepted
// Build macro: SCANOUT_PREFETCH_EN overlaps the next word fetch with pixel
// output so the stream has no per-word bubble.
module vid_scanout
  import scanout_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned NUM_BYTES     = 1408,
  parameter int unsigned ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [ADDRESS_WIDTH-1:0] vaddr,
  input  logic [31:0]              vdata,
  output logic                     pix_valid,
  output logic [7:0]               pix_data,
  input  logic                     pix_ready,
  output logic                     pix_last,
  output logic                     busy,
  output logic                     frame_done
);

  localparam logic [ADDRESS_WIDTH-1:0] BASE      = ADDRESS_WIDTH'(BASE_ADDR);
  localparam logic [ADDRESS_WIDTH-1:0] WORD_STEP = ADDRESS_WIDTH'(BYTES_PER_WORD);
  localparam logic [31:0]              NB32      = 32'(NUM_BYTES);
  localparam logic [31:0]              LAST_CNT  = 32'(NUM_BYTES - 1);

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] vaddr_q, vaddr_d;
  logic [31:0]              cnt_q, cnt_d;
  logic                     busy_q, busy_d;

  logic                     accept;
  logic                     cnt_last;
  logic                     word_end;
  logic                     ser_load;
  logic                     ser_adv;
  logic [IDX_W-1:0]         idx;
  logic [7:0]               ser_byte;

`ifdef SCANOUT_PREFETCH_EN
  logic pf_issue;
  logic ser_swap;
  logic pf_wait_q;  // prefetch address is being sampled by the memory
  logic pf_ld_q;    // prefetch data is on vdata this cycle
`endif

  assign accept   = (state_q == SHIFT) && pix_ready;
  assign cnt_last = (cnt_q == LAST_CNT);
  assign word_end = (idx == LAST_IDX);

  pix_serializer u_ser (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .load_i    (ser_load),
    .adv_i     (ser_adv),
    .word_i    (vdata),
`ifdef SCANOUT_PREFETCH_EN
    .pf_load_i (pf_ld_q),
    .swap_i    (ser_swap),
`endif
    .idx_o     (idx),
    .byte_o    (ser_byte)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = FETCH;
      FETCH: state_d = LOAD;
      LOAD:  state_d = SHIFT;
      SHIFT: begin
        if (accept) begin
          if (cnt_last) begin
            state_d = DONE;
          end else if (word_end) begin
`ifdef SCANOUT_PREFETCH_EN
            state_d = SHIFT;
`else
            state_d = FETCH;
`endif
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address, byte counter and serializer control
  always_comb begin
    vaddr_d  = vaddr_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    ser_load = 1'b0;
    ser_adv  = 1'b0;
`ifdef SCANOUT_PREFETCH_EN
    pf_issue = 1'b0;
    ser_swap = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          vaddr_d = BASE;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        ser_load = 1'b1;
`ifdef SCANOUT_PREFETCH_EN
        // cnt_q is the first byte of the word being loaded; fetch the
        // following word only if the frame reaches into it.
        if (cnt_q + 32'd4 < NB32) begin
          vaddr_d  = vaddr_q + WORD_STEP;
          pf_issue = 1'b1;
        end
`endif
      end
      SHIFT: begin
        if (accept) begin
          cnt_d = cnt_q + 32'd1;
          if (!cnt_last) begin
            if (word_end) begin
`ifdef SCANOUT_PREFETCH_EN
              // The prefetched word (issued at least four edges ago, latched
              // two edges after issue) becomes current; the word after it
              // starts at byte cnt_q+5.
              ser_swap = 1'b1;
              if (cnt_q + 32'd5 < NB32) begin
                vaddr_d  = vaddr_q + WORD_STEP;
                pf_issue = 1'b1;
              end
`else
              vaddr_d = vaddr_q + WORD_STEP;
`endif
            end else begin
              ser_adv = 1'b1;
            end
          end
        end
      end
      DONE: busy_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vaddr_q <= BASE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      vaddr_q <= vaddr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

`ifdef SCANOUT_PREFETCH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_wait_q <= 1'b0;
      pf_ld_q   <= 1'b0;
    end else begin
      pf_wait_q <= pf_issue;
      pf_ld_q   <= pf_wait_q;
    end
  end
`endif

  // Output logic
  always_comb begin
    pix_valid  = (state_q == SHIFT);
    pix_data   = pix_valid ? ser_byte : '0;
    pix_last   = pix_valid && cnt_last;
    frame_done = (state_q == DONE);
  end

  assign vaddr = vaddr_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_vid_scanout.sv
// Testbench for vid_scanout: three instances (8-byte frame, 6-byte partial
// frame, 13-byte frame wrapping the 32-bit address space) sharing one
// synchronous-read memory model. Expected pixels come from the byte address
// arithmetic of the frame; timing expectations follow the FETCH/LOAD bubble
// rules, or the bubble-free stream when SCANOUT_PREFETCH_EN is defined.
module tb_vid_scanout;

  localparam int NDUT = 3;
  localparam logic [31:0] BA [NDUT] = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFF8};
  localparam int          NB [NDUT] = '{8, 6, 13};
`ifdef SCANOUT_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start     [NDUT];
  logic        pix_ready [NDUT];
  logic [31:0] vaddr     [NDUT];
  logic [31:0] vdata     [NDUT];
  logic        pix_valid [NDUT];
  logic [7:0]  pix_data  [NDUT];
  logic        pix_last  [NDUT];
  logic        busy      [NDUT];
  logic        frame_done[NDUT];
  logic [31:0] mem [16];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < NDUT; g++) begin : g_dut
      vid_scanout #(
        .BASE_ADDR    (BA[g]),
        .NUM_BYTES    (NB[g]),
        .ADDRESS_WIDTH(32)
      ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start[g]),
        .vaddr      (vaddr[g]),
        .vdata      (vdata[g]),
        .pix_valid  (pix_valid[g]),
        .pix_data   (pix_data[g]),
        .pix_ready  (pix_ready[g]),
        .pix_last   (pix_last[g]),
        .busy       (busy[g]),
        .frame_done (frame_done[g])
      );
      always @(posedge clk) vdata[g] <= mem[vaddr[g][5:2]];
    end
  endgenerate

  // Frame model: pixel k is the byte at address BASE+k, little-endian lanes.
  function automatic logic [7:0] exp_pix(input int d, input int k);
    logic [31:0] a;
    logic [31:0] w;
    a = BA[d] + 32'(k);
    w = mem[a[5:2]];
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic int n_words(input int d);
    return (NB[d] + 3) / 4;
  endfunction

  // Observation index (negedges after the start edge) where frame_done shows
  // with pix_ready held high.
  function automatic int exp_done_at(input int d);
    return PF ? NB[d] + 3 : 2 * n_words(d) + NB[d] + 1;
  endfunction

  // Observations of one frame
  logic [7:0]  obs_pix[$];
  bit          obs_lastf[$];
  logic [31:0] obs_addrs[$];
  int obs_first, obs_done_at, obs_done_cnt, obs_done_gap;
  int obs_gaps, obs_unstable, obs_last_wo_valid;
  logic obs_busy_after;
  bit   obs_timeout;

  // Drive one frame on instance d and record what the sink sees.
  // mode 0: ready high, 1: ready toggling, 2: ready random.
  // restart_at: observation index at which a second start pulse is driven (0 = none).
  task automatic run_frame(input int d, input int mode, input int restart_at, input int max_cyc);
    logic [7:0] prev_data;
    logic       prev_last, prev_stall, r;
    int         last_acc;
    obs_pix.delete(); obs_lastf.delete(); obs_addrs.delete();
    obs_first = -1; obs_done_at = -1; obs_done_cnt = 0; obs_done_gap = -1;
    obs_gaps = 0; obs_unstable = 0; obs_last_wo_valid = 0;
    obs_busy_after = 1'bx; obs_timeout = 1'b0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; last_acc = -100;
    @(negedge clk);
    start[d] = 1'b1;
    pix_ready[d] = 1'b0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      start[d] = (i == restart_at);
      if (obs_done_at >= 0 && i == obs_done_at + 1) begin
        obs_busy_after = busy[d];
      end
      if (frame_done[d]) begin
        obs_done_cnt++;
        if (obs_done_at < 0) begin
          obs_done_at  = i;
          obs_done_gap = i - last_acc;
        end
      end
      if (pix_valid[d] && obs_first < 0) obs_first = i;
      if (obs_first >= 0 && obs_done_at < 0 && !pix_valid[d] && !frame_done[d]) obs_gaps++;
      if (prev_stall && (!pix_valid[d] || pix_data[d] !== prev_data || pix_last[d] !== prev_last))
        obs_unstable++;
      if (pix_last[d] && !pix_valid[d]) obs_last_wo_valid++;
      if (busy[d] && (obs_addrs.size() == 0 || obs_addrs[$] !== vaddr[d]))
        obs_addrs.push_back(vaddr[d]);
      case (mode)
        0:       r = 1'b1;
        1:       r = (i % 2) == 1;
        default: r = 1'($urandom_range(0, 1));
      endcase
      pix_ready[d] = r;
      if (pix_valid[d] && r) begin
        obs_pix.push_back(pix_data[d]);
        obs_lastf.push_back(pix_last[d]);
        last_acc = i;
      end
      prev_stall = pix_valid[d] && !r;
      prev_data  = pix_data[d];
      prev_last  = pix_last[d];
      if (obs_done_at >= 0 && i >= obs_done_at + 1) break;
    end
    if (obs_done_at < 0) obs_timeout = 1'b1;
    start[d] = 1'b0;
    pix_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < NDUT; d++) begin
      checks++; if (pix_valid[d] !== 1'b0) begin failures++; $display("FAIL reset_valid[%0d]: got %b expected 0", d, pix_valid[d]); end
      checks++; if (pix_last[d] !== 1'b0) begin failures++; $display("FAIL reset_last[%0d]: got %b expected 0", d, pix_last[d]); end
      checks++; if (busy[d] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d]: got %b expected 0", d, busy[d]); end
      checks++; if (frame_done[d] !== 1'b0) begin failures++; $display("FAIL reset_done[%0d]: got %b expected 0", d, frame_done[d]); end
      checks++; if (pix_data[d] !== 8'h00) begin failures++; $display("FAIL reset_data[%0d]: got %h expected 00", d, pix_data[d]); end
      checks++; if (vaddr[d] !== BA[d]) begin failures++; $display("FAIL reset_vaddr[%0d]: got %h expected %h", d, vaddr[d], BA[d]); end
    end
  endtask

  task automatic test_basic_frame();
    logic [31:0] ea;
    mem[0] = 32'h4433_2211;
    mem[1] = 32'h8877_6655;
    run_frame(0, 0, 0, 80);
    checks++; if (obs_timeout) begin failures++; $display("FAIL basic_timeout: got no frame_done expected frame_done"); end
    checks++; if (obs_pix.size() != 8) begin failures++; $display("FAIL basic_count: got %0d expected 8", obs_pix.size()); end
    for (int k = 0; k < 8; k++) begin
      logic [7:0] got;
      got = 'x;
      if (k < obs_pix.size()) got = obs_pix[k];
      checks++; if (got !== exp_pix(0, k)) begin failures++; $display("FAIL basic_pix%0d: got %h expected %h", k, got, exp_pix(0, k)); end
    end
    for (int k = 0; k < obs_lastf.size(); k++) begin
      checks++; if (obs_lastf[k] !== (k == 7)) begin failures++; $display("FAIL basic_last%0d: got %b expected %b", k, obs_lastf[k], k == 7); end
    end
    checks++; if (obs_last_wo_valid != 0) begin failures++; $display("FAIL basic_last_idle: got %0d expected 0", obs_last_wo_valid); end
    checks++; if (obs_first != 3) begin failures++; $display("FAIL basic_first_valid: got %0d expected 3", obs_first); end
    checks++; if (obs_gaps != (PF ? 0 : 2)) begin failures++; $display("FAIL basic_bubbles: got %0d expected %0d", obs_gaps, PF ? 0 : 2); end
    checks++; if (obs_done_at != exp_done_at(0)) begin failures++; $display("FAIL basic_done_time: got %0d expected %0d", obs_done_at, exp_done_at(0)); end
    checks++; if (obs_done_gap != 1) begin failures++; $display("FAIL basic_done_gap: got %0d expected 1", obs_done_gap); end
    checks++; if (obs_done_cnt != 1) begin failures++; $display("FAIL basic_done_count: got %0d expected 1", obs_done_cnt); end
    checks++; if (obs_busy_after !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %b expected 0", obs_busy_after); end
    checks++; if (obs_addrs.size() != 2) begin failures++; $display("FAIL basic_addr_count: got %0d expected 2", obs_addrs.size()); end
    for (int w = 0; w < 2 && w < obs_addrs.size(); w++) begin
      ea = BA[0] + 32'(4 * w);
      checks++; if (obs_addrs[w] !== ea) begin failures++; $display("FAIL basic_vaddr%0d: got %h expected %h", w, obs_addrs[w], ea); end
    end
  endtask

  task automatic test_backpressure();
    for (int run = 0; run < 3; run++) begin
      if (run > 0) begin
        mem[0] = $urandom;
        mem[1] = $urandom;
      end
      run_frame(0, run == 0 ? 1 : 2, 0, 200);
      checks++; if (obs_timeout) begin failures++; $display("FAIL bp%0d_timeout: got no frame_done expected frame_done", run); end
      checks++; if (obs_pix.size() != 8) begin failures++; $display("FAIL bp%0d_count: got %0d expected 8", run, obs_pix.size()); end
      for (int k = 0; k < obs_pix.size() && k < 8; k++) begin
        checks++; if (obs_pix[k] !== exp_pix(0, k)) begin failures++; $display("FAIL bp%0d_pix%0d: got %h expected %h", run, k, obs_pix[k], exp_pix(0, k)); end
        checks++; if (obs_lastf[k] !== (k == 7)) begin failures++; $display("FAIL bp%0d_last%0d: got %b expected %b", run, k, obs_lastf[k], k == 7); end
      end
      checks++; if (obs_unstable != 0) begin failures++; $display("FAIL bp%0d_stall_stable: got %0d changes expected 0", run, obs_unstable); end
      checks++; if (obs_done_cnt != 1 || obs_done_gap != 1) begin failures++; $display("FAIL bp%0d_done: got count %0d gap %0d expected count 1 gap 1", run, obs_done_cnt, obs_done_gap); end
    end
  endtask

  task automatic test_partial_word();
    mem[0] = 32'h4433_2211;
    mem[1] = 32'h8877_6655;
    mem[2] = 32'hCCBB_AA99;
    for (int run = 0; run < 2; run++) begin
      run_frame(1, run == 0 ? 0 : 2, 0, 120);
      checks++; if (obs_pix.size() != 6) begin failures++; $display("FAIL part%0d_count: got %0d expected 6", run, obs_pix.size()); end
      for (int k = 0; k < obs_pix.size() && k < 6; k++) begin
        checks++; if (obs_pix[k] !== exp_pix(1, k)) begin failures++; $display("FAIL part%0d_pix%0d: got %h expected %h", run, k, obs_pix[k], exp_pix(1, k)); end
        checks++; if (obs_lastf[k] !== (k == 5)) begin failures++; $display("FAIL part%0d_last%0d: got %b expected %b", run, k, obs_lastf[k], k == 5); end
      end
      checks++; if (obs_addrs.size() != 2 || obs_addrs[0] !== 32'h0 || obs_addrs[obs_addrs.size()-1] !== 32'h4)
        begin failures++; $display("FAIL part%0d_vaddr: got %0d addrs ending %h expected 2 addrs 0,4", run, obs_addrs.size(), obs_addrs[obs_addrs.size()-1]); end
      if (run == 0) begin
        checks++; if (obs_done_at != exp_done_at(1)) begin failures++; $display("FAIL part_done_time: got %0d expected %0d", obs_done_at, exp_done_at(1)); end
      end
    end
  endtask

  task automatic test_wrap_random();
    logic [31:0] ea;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    run_frame(2, 2, 0, 300);
    checks++; if (obs_pix.size() != 13) begin failures++; $display("FAIL wrap_count: got %0d expected 13", obs_pix.size()); end
    for (int k = 0; k < obs_pix.size() && k < 13; k++) begin
      checks++; if (obs_pix[k] !== exp_pix(2, k)) begin failures++; $display("FAIL wrap_pix%0d: got %h expected %h", k, obs_pix[k], exp_pix(2, k)); end
    end
    checks++; if (obs_addrs.size() != n_words(2)) begin failures++; $display("FAIL wrap_addr_count: got %0d expected %0d", obs_addrs.size(), n_words(2)); end
    for (int w = 0; w < n_words(2) && w < obs_addrs.size(); w++) begin
      ea = BA[2] + 32'(4 * w);
      checks++; if (obs_addrs[w] !== ea) begin failures++; $display("FAIL wrap_vaddr%0d: got %h expected %h", w, obs_addrs[w], ea); end
    end
    checks++; if (obs_unstable != 0) begin failures++; $display("FAIL wrap_stall_stable: got %0d expected 0", obs_unstable); end
  endtask

  task automatic test_start_while_busy();
    int busy_seen;
    mem[0] = 32'h4433_2211;
    mem[1] = 32'h8877_6655;
    for (int run = 0; run < 2; run++) begin
      run_frame(0, 0, run == 0 ? 5 : exp_done_at(0), 80);
      checks++; if (obs_done_cnt != 1) begin failures++; $display("FAIL sb%0d_done_count: got %0d expected 1", run, obs_done_cnt); end
      checks++; if (obs_pix.size() != 8) begin failures++; $display("FAIL sb%0d_count: got %0d expected 8", run, obs_pix.size()); end
      busy_seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (busy[0] || pix_valid[0]) busy_seen++;
      end
      checks++; if (busy_seen != 0) begin failures++; $display("FAIL sb%0d_no_requeue: got %0d busy cycles expected 0", run, busy_seen); end
    end
    run_frame(0, 0, 0, 80);
    checks++; if (obs_pix.size() != 8 || obs_pix[0] !== exp_pix(0, 0)) begin failures++; $display("FAIL sb_restart: got %0d pixels first %h expected 8 first %h", obs_pix.size(), obs_pix[0], exp_pix(0, 0)); end
  endtask

  task automatic test_reset_mid_frame();
    int acc;
    int idle_bad;
    acc = 0;
    @(negedge clk);
    start[0] = 1'b1;
    pix_ready[0] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (pix_valid[0]) acc++;
      if (acc == 6) break;
    end
    checks++; if (acc != 6) begin failures++; $display("FAIL rst_reach_word1: got %0d pixels expected 6", acc); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pix_valid[0] !== 1'b0 || pix_last[0] !== 1'b0 || pix_data[0] !== 8'h00)
      begin failures++; $display("FAIL rst_mid_pix: got valid %b last %b data %h expected 0 0 00", pix_valid[0], pix_last[0], pix_data[0]); end
    checks++; if (busy[0] !== 1'b0 || frame_done[0] !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got busy %b done %b expected 0 0", busy[0], frame_done[0]); end
    checks++; if (vaddr[0] !== BA[0]) begin failures++; $display("FAIL rst_mid_vaddr: got %h expected %h", vaddr[0], BA[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy[0] || pix_valid[0]) idle_bad++;
    end
    pix_ready[0] = 1'b0;
    checks++; if (idle_bad != 0) begin failures++; $display("FAIL rst_no_resume: got %0d active cycles expected 0", idle_bad); end
    run_frame(0, 0, 0, 80);
    checks++; if (obs_pix.size() != 8) begin failures++; $display("FAIL rst_replay_count: got %0d expected 8", obs_pix.size()); end
    for (int k = 0; k < obs_pix.size() && k < 8; k++) begin
      checks++; if (obs_pix[k] !== exp_pix(0, k)) begin failures++; $display("FAIL rst_replay_pix%0d: got %h expected %h", k, obs_pix[k], exp_pix(0, k)); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      start[d] = 1'b0;
      pix_ready[d] = 1'b0;
    end
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_partial_word();
    test_wrap_random();
    test_start_while_busy();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
